// File: rtl/triangle_raster_scan_if.sv
// Triangle-in / pixel-out handshake bundle for triangle_raster_scan.
// master = triangle source and pixel sink, slave = the raster scanner.
interface triangle_raster_scan_if #(
   parameter int W = 12
);
   logic         tri_valid;
   logic         tri_ready;
   logic [W-1:0] ax;
   logic [W-1:0] ay;
   logic [W-1:0] bx;
   logic [W-1:0] by;
   logic [W-1:0] cx;
   logic [W-1:0] cy;
   logic         pix_valid;
   logic         pix_ready;
   logic [W-1:0] pix_x;
   logic [W-1:0] pix_y;

   modport master (
      output tri_valid, ax, ay, bx, by, cx, cy, pix_ready,
      input  tri_ready, pix_valid, pix_x, pix_y
   );

   modport slave (
      input  tri_valid, ax, ay, bx, by, cx, cy, pix_ready,
      output tri_ready, pix_valid, pix_x, pix_y
   );
endinterface

// File: rtl/triangle_raster_scan.sv
// Bounding-box raster walker feeding a combinational point-in-triangle tester.
// Optional RASTER_PIXCOUNT_EN adds a per-triangle pix_count output.
module triangle_raster_scan #(
   parameter int W = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   triangle_raster_scan_if.slave bus,
   output logic [W-1:0]         px,
   output logic [W-1:0]         py,
   input  logic                 in_tri,
   output logic                 busy,
   output logic                 done
`ifdef RASTER_PIXCOUNT_EN
   ,
   output logic [2*W-1:0]       pix_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_BBOX = 3'd1,
      S_SCAN = 3'd2,
      S_EMIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t state_r, state_nxt_s;

   logic [W-1:0] ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
   logic [W-1:0] ax_nxt_s, ay_nxt_s, bx_nxt_s, by_nxt_s, cx_nxt_s, cy_nxt_s;
   logic [W-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
   logic [W-1:0] xmin_nxt_s, xmax_nxt_s, ymin_nxt_s, ymax_nxt_s;
   logic [W-1:0] px_r, py_r, px_nxt_s, py_nxt_s;
   logic [W-1:0] adv_px_s, adv_py_s;
   logic [W-1:0] pix_x_r, pix_y_r, pix_x_nxt_s, pix_y_nxt_s;
   logic         pix_valid_r, pix_valid_nxt_s;
   logic         busy_r, done_r, tri_ready_r;
   logic         accept_s, last_x_s, last_y_s, last_pt_s;

   function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
      logic [W-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
      logic [W-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   assign accept_s  = bus.tri_valid && tri_ready_r;
   // Equality compares keep a box edge at 2^W-1 from wrapping.
   assign last_x_s  = (px_r == xmax_r);
   assign last_y_s  = (py_r == ymax_r);
   assign last_pt_s = last_x_s && last_y_s;

   // Raster advance: step right, wrap to xmin on the next row, hold on the last point.
   always_comb begin
      adv_px_s = px_r;
      adv_py_s = py_r;
      if (!last_x_s) begin
         adv_px_s = px_r + W'(1);
      end else if (!last_y_s) begin
         adv_px_s = xmin_r;
         adv_py_s = py_r + W'(1);
      end else begin
         adv_px_s = px_r;
         adv_py_s = py_r;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: state_nxt_s = accept_s ? S_BBOX : S_IDLE;
         S_BBOX: state_nxt_s = S_SCAN;
         S_SCAN: begin
            if (in_tri)         state_nxt_s = S_EMIT;
            else if (last_pt_s) state_nxt_s = S_DONE;
            else                state_nxt_s = S_SCAN;
         end
         S_EMIT: begin
            if (!bus.pix_ready) state_nxt_s = S_EMIT;
            else if (last_pt_s) state_nxt_s = S_DONE;
            else                state_nxt_s = S_SCAN;
         end
         S_DONE:  state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Datapath and output next values for each state.
   always_comb begin
      ax_nxt_s = ax_r; ay_nxt_s = ay_r; bx_nxt_s = bx_r;
      by_nxt_s = by_r; cx_nxt_s = cx_r; cy_nxt_s = cy_r;
      xmin_nxt_s = xmin_r; xmax_nxt_s = xmax_r;
      ymin_nxt_s = ymin_r; ymax_nxt_s = ymax_r;
      px_nxt_s = px_r; py_nxt_s = py_r;
      pix_x_nxt_s = pix_x_r; pix_y_nxt_s = pix_y_r;
      pix_valid_nxt_s = pix_valid_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               ax_nxt_s = bus.ax; ay_nxt_s = bus.ay; bx_nxt_s = bus.bx;
               by_nxt_s = bus.by; cx_nxt_s = bus.cx; cy_nxt_s = bus.cy;
            end else begin
               ax_nxt_s = ax_r;
            end
         end
         S_BBOX: begin
            xmin_nxt_s = min3(ax_r, bx_r, cx_r);
            xmax_nxt_s = max3(ax_r, bx_r, cx_r);
            ymin_nxt_s = min3(ay_r, by_r, cy_r);
            ymax_nxt_s = max3(ay_r, by_r, cy_r);
            px_nxt_s   = min3(ax_r, bx_r, cx_r);
            py_nxt_s   = min3(ay_r, by_r, cy_r);
         end
         S_SCAN: begin
            if (in_tri) begin
               pix_x_nxt_s     = px_r;
               pix_y_nxt_s     = py_r;
               pix_valid_nxt_s = 1'b1;
            end else begin
               px_nxt_s = adv_px_s;
               py_nxt_s = adv_py_s;
            end
         end
         S_EMIT: begin
            if (bus.pix_ready) begin
               pix_valid_nxt_s = 1'b0;
               px_nxt_s        = adv_px_s;
               py_nxt_s        = adv_py_s;
            end else begin
               pix_valid_nxt_s = 1'b1;
            end
         end
         S_DONE:  pix_valid_nxt_s = 1'b0;
         default: pix_valid_nxt_s = 1'b0;
      endcase
   end

   // State and datapath registers; status flags are registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= S_IDLE;
         ax_r <= '0; ay_r <= '0; bx_r <= '0; by_r <= '0; cx_r <= '0; cy_r <= '0;
         xmin_r <= '0; xmax_r <= '0; ymin_r <= '0; ymax_r <= '0;
         px_r        <= '0;
         py_r        <= '0;
         pix_x_r     <= '0;
         pix_y_r     <= '0;
         pix_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         tri_ready_r <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         ax_r <= ax_nxt_s; ay_r <= ay_nxt_s; bx_r <= bx_nxt_s;
         by_r <= by_nxt_s; cx_r <= cx_nxt_s; cy_r <= cy_nxt_s;
         xmin_r <= xmin_nxt_s; xmax_r <= xmax_nxt_s;
         ymin_r <= ymin_nxt_s; ymax_r <= ymax_nxt_s;
         px_r        <= px_nxt_s;
         py_r        <= py_nxt_s;
         pix_x_r     <= pix_x_nxt_s;
         pix_y_r     <= pix_y_nxt_s;
         pix_valid_r <= pix_valid_nxt_s;
         busy_r      <= (state_nxt_s != S_IDLE);
         done_r      <= (state_nxt_s == S_DONE);
         tri_ready_r <= (state_nxt_s == S_IDLE);
      end
   end

`ifdef RASTER_PIXCOUNT_EN
   logic [2*W-1:0] pix_count_r;

   // Pixels accepted downstream for the current triangle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_count_r <= '0;
      end else if (accept_s) begin
         pix_count_r <= '0;
      end else if (pix_valid_r && bus.pix_ready) begin
         pix_count_r <= pix_count_r + (2*W)'(1);
      end else begin
         pix_count_r <= pix_count_r;
      end
   end

   assign pix_count = pix_count_r;
`endif

   assign bus.tri_ready = tri_ready_r;
   assign bus.pix_valid = pix_valid_r;
   assign bus.pix_x     = pix_x_r;
   assign bus.pix_y     = pix_y_r;
   assign px            = px_r;
   assign py            = py_r;
   assign busy          = busy_r;
   assign done          = done_r;

endmodule

// File: tb/tb_triangle_raster_scan.sv
// Directed bench for triangle_raster_scan with an edge-function tester model.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_triangle_raster_scan;
   localparam int W = 12;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] px, py;
   logic         in_tri, busy, done;
   int           mode;  // 0 = tester model, 1 = force 0, 2 = force 1
   int           vax, vay, vbx, vby, vcx, vcy;
   int           errors = 0;
   int           checks = 0;
   int           n;
`ifdef RASTER_PIXCOUNT_EN
   logic [2*W-1:0] pix_count;
`endif

   always #5 clk = ~clk;

   triangle_raster_scan_if #(.W(W)) bus ();

   triangle_raster_scan #(.W(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .px     (px),
      .py     (py),
      .in_tri (in_tri),
      .busy   (busy),
      .done   (done)
`ifdef RASTER_PIXCOUNT_EN
      ,
      .pix_count (pix_count)
`endif
   );

   function automatic logic tri_model(input int x, input int y, input int a_x, input int a_y,
                                      input int b_x, input int b_y, input int c_x, input int c_y);
      int e0, e1, e2;
      e0 = (b_x - a_x) * (y - a_y) - (b_y - a_y) * (x - a_x);
      e1 = (c_x - b_x) * (y - b_y) - (c_y - b_y) * (x - b_x);
      e2 = (a_x - c_x) * (y - c_y) - (a_y - c_y) * (x - c_x);
      return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
   endfunction

   assign in_tri = (mode == 2) ? 1'b1 :
                   (mode == 1) ? 1'b0 :
                   tri_model(int'(px), int'(py), vax, vay, vbx, vby, vcx, vcy);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers a triangle, returns one sample after the accepting edge (BBOX cycle).
   task automatic start_tri(input int a_x, input int a_y, input int b_x, input int b_y,
                            input int c_x, input int c_y);
      for (int i = 0; i < 50 && bus.tri_ready !== 1'b1; i++) step();
      checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL start_tri_ready: got %0b expected 1", bus.tri_ready); end
      vax = a_x; vay = a_y; vbx = b_x; vby = b_y; vcx = c_x; vcy = c_y;
      bus.ax = W'(a_x); bus.ay = W'(a_y); bus.bx = W'(b_x);
      bus.by = W'(b_y); bus.cx = W'(c_x); bus.cy = W'(c_y);
      bus.tri_valid = 1'b1;
      step();
      bus.tri_valid = 1'b0;
      bus.ax = W'(999); bus.ay = W'(888); bus.bx = W'(0);
      bus.by = W'(4095); bus.cx = W'(77); bus.cy = W'(1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL accept_busy: got %0b expected 1", busy); end
      checks++; if (bus.tri_ready !== 1'b0) begin errors++; $display("FAIL accept_tri_ready: got %0b expected 0", bus.tri_ready); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mode = 1;
      bus.tri_valid = 1'b0; bus.pix_ready = 1'b0;
      bus.ax = '0; bus.ay = '0; bus.bx = '0; bus.by = '0; bus.cx = '0; bus.cy = '0;
      #12;
      checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL reset_tri_ready: got %0b expected 1", bus.tri_ready); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b%0b expected 00", busy, done); end
      checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %0b expected 0", bus.pix_valid); end
      checks++; if (px !== 12'd0 || py !== 12'd0 || bus.pix_x !== 12'd0 || bus.pix_y !== 12'd0) begin errors++; $display("FAIL reset_coords: got %0d,%0d,%0d,%0d expected 0,0,0,0", px, py, bus.pix_x, bus.pix_y); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_point();
      mode = 0;
      bus.pix_ready = 1'b1;
      start_tri(5, 7, 5, 7, 5, 7);
      step();
      checks++; if (px !== 12'd5 || py !== 12'd7) begin errors++; $display("FAIL single_scan_point: got (%0d,%0d) expected (5,7)", px, py); end
      checks++; if (bus.pix_valid !== 1'b0) begin errors++; $display("FAIL single_no_early_pix: got %0b expected 0", bus.pix_valid); end
      step();
      checks++; if (bus.pix_valid !== 1'b1 || bus.pix_x !== 12'd5 || bus.pix_y !== 12'd7) begin errors++; $display("FAIL single_pixel: got v=%0b (%0d,%0d) expected v=1 (5,7)", bus.pix_valid, bus.pix_x, bus.pix_y); end
      step();
      checks++; if (done !== 1'b1 || bus.pix_valid !== 1'b0) begin errors++; $display("FAIL single_done: got done=%0b v=%0b expected done=1 v=0", done, bus.pix_valid); end
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0 || bus.tri_ready !== 1'b1) begin errors++; $display("FAIL single_idle: got done=%0b busy=%0b rdy=%0b expected 0 0 1", done, busy, bus.tri_ready); end
   endtask

   task automatic test_scan_outside();
      mode = 1;
      bus.pix_ready = 1'b1;
      start_tri(4, 3, 2, 5, 3, 4);
      step();
      for (int i = 0; i < 9; i++) begin
         // A competing triangle offered while busy must be ignored.
         bus.tri_valid = (i < 8);
         checks++; if (px !== W'(2 + i % 3) || py !== W'(3 + i / 3) || bus.pix_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL outside_point%0d: got (%0d,%0d) v=%0b d=%0b expected (%0d,%0d) v=0 d=0", i, px, py, bus.pix_valid, done, 2 + i % 3, 3 + i / 3); end
         step();
      end
      bus.tri_valid = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL outside_done: got %0b expected 1", done); end
      step();
      checks++; if (bus.tri_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL outside_idle: got rdy=%0b busy=%0b expected 1 0", bus.tri_ready, busy); end
   endtask

   task automatic test_backpressure();
      mode = 2;
      bus.pix_ready = 1'b0;
      start_tri(4, 3, 2, 5, 3, 4);
      step();
      step();
      for (int k = 0; k < 5; k++) begin
         checks++; if (bus.pix_valid !== 1'b1 || bus.pix_x !== 12'd2 || bus.pix_y !== 12'd3) begin errors++; $display("FAIL hold_cycle%0d: got v=%0b (%0d,%0d) expected v=1 (2,3)", k, bus.pix_valid, bus.pix_x, bus.pix_y); end
         step();
      end
      bus.pix_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 100 && done !== 1'b1; c++) begin
         if (bus.pix_valid === 1'b1) begin
            checks++; if (bus.pix_x !== W'(2 + n % 3) || bus.pix_y !== W'(3 + n / 3)) begin errors++; $display("FAIL order_pix%0d: got (%0d,%0d) expected (%0d,%0d)", n, bus.pix_x, bus.pix_y, 2 + n % 3, 3 + n / 3); end
            n++;
         end
         step();
      end
      checks++; if (done !== 1'b1 || n != 9) begin errors++; $display("FAIL backpressure_count: got done=%0b pixels=%0d expected done=1 pixels=9", done, n); end
      step();
   endtask

   task automatic test_wide_x();
      mode = 1;
      bus.pix_ready = 1'b1;
      start_tri(4095, 0, 4093, 0, 4094, 0);
      step();
      for (int i = 0; i < 3; i++) begin
         checks++; if (px !== W'(4093 + i) || py !== 12'd0 || done !== 1'b0) begin errors++; $display("FAIL wide_point%0d: got (%0d,%0d) d=%0b expected (%0d,0) d=0", i, px, py, done, 4093 + i); end
         step();
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL wide_done: got %0b expected 1", done); end
      step();
   endtask

   task automatic test_reset_mid_scan();
      mode = 2;
      bus.pix_ready = 1'b0;
      start_tri(10, 20, 12, 20, 10, 21);
      step();
      step();
      checks++; if (bus.pix_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %0b expected 1", bus.pix_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.pix_valid !== 1'b0 || busy !== 1'b0 || bus.tri_ready !== 1'b1) begin errors++; $display("FAIL midrst_async: got v=%0b busy=%0b rdy=%0b expected 0 0 1", bus.pix_valid, busy, bus.tri_ready); end
      checks++; if (px !== 12'd0 || py !== 12'd0 || bus.pix_x !== 12'd0 || bus.pix_y !== 12'd0) begin errors++; $display("FAIL midrst_coords: got %0d,%0d,%0d,%0d expected 0,0,0,0", px, py, bus.pix_x, bus.pix_y); end
      #2 rst_n = 1'b1;
      step();
      mode = 1;
      start_tri(7, 9, 8, 9, 7, 10);
      step();
      checks++; if (px !== 12'd7 || py !== 12'd9) begin errors++; $display("FAIL midrst_restart: got (%0d,%0d) expected (7,9)", px, py); end
      for (int i = 0; i < 4; i++) step();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_done: got %0b expected 1", done); end
      step();
   endtask

`ifdef RASTER_PIXCOUNT_EN
   task automatic test_pix_count();
      mode = 2;
      bus.pix_ready = 1'b1;
      start_tri(0, 0, 2, 1, 0, 1);
      for (int c = 0; c < 100 && done !== 1'b1; c++) step();
      checks++; if (done !== 1'b1 || pix_count !== 24'd6) begin errors++; $display("FAIL pixcount_done: got done=%0b count=%0d expected done=1 count=6", done, pix_count); end
      step();
      mode = 1;
      start_tri(1, 1, 1, 1, 1, 1);
      checks++; if (pix_count !== 24'd0) begin errors++; $display("FAIL pixcount_clear: got %0d expected 0", pix_count); end
      for (int c = 0; c < 20 && done !== 1'b1; c++) step();
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_single_point();
      test_scan_outside();
      test_backpressure();
      test_wide_x();
      test_reset_mid_scan();
`ifdef RASTER_PIXCOUNT_EN
      test_pix_count();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
